// File: rtl/dma_path_top.sv
// DMA loopback datapath: BRAM -> MM2S engine -> 128-bit stream -> S2MM engine -> BRAM.
// Optional feature macro: DMA_PATH_FIFO_EN inserts a 4-entry stream FIFO between the engines.

module dma_path_bram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

    // NOTE: storage and read register have no reset; BRAM contents survive rstn.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

module dma_path_top #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go_mm2s,
    input  logic              go_s2mm,
    input  logic [31:0]       byte_len,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              mm2s_done,
    output logic              s2mm_done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [31:0] beat_count(input logic [31:0] len);
        logic [32:0] sum;
        sum = {1'b0, len} + 33'd15;
        return 32'(sum >> 4);
    endfunction

    state_t            mm2s_st, s2mm_st;
    logic [ADDR_W-1:0] rd_base, wr_base, rd_addr, wr_addr;
    logic [31:0]       rd_n, rd_issued, wr_n, wr_cnt, go_beats;
    logic              rd_en, wr_en;
    logic [DATA_W-1:0] rd_data;
    logic              m_valid, m_last, m_ready;
    logic [DATA_W-1:0] m_data;
    logic              s_valid, s_last, s_ready;
    logic [DATA_W-1:0] s_data;

    assign go_beats = beat_count(byte_len);

    dma_path_bram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_data)
    );

    // The BRAM read register is the MM2S prefetch stage; a read is issued only
    // when that stage is empty or being drained, so nothing is ever overwritten.
    assign m_data  = rd_data;
    assign rd_en   = (mm2s_st == RUN) && (rd_issued != rd_n) && (!m_valid || m_ready);
    assign rd_addr = rd_base + rd_issued[ADDR_W-1:0];

    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mm2s_st   <= IDLE;
            mm2s_done <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            rd_base   <= '0;
            rd_n      <= '0;
            rd_issued <= '0;
        end else if (mm2s_st == RUN) begin
            if (rd_en) begin
                rd_issued <= rd_issued + 32'd1;
                m_valid   <= 1'b1;
                m_last    <= (rd_issued == rd_n - 32'd1);
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (m_valid && m_ready && m_last) begin
                mm2s_st   <= DONE;
                mm2s_done <= 1'b1;
            end
        end else if (go_mm2s) begin
            rd_base   <= in_base;
            rd_n      <= go_beats;
            rd_issued <= '0;
            m_valid   <= 1'b0;
            if (go_beats == 32'd0) begin
                mm2s_st   <= DONE;
                mm2s_done <= 1'b1;
            end else begin
                mm2s_st   <= RUN;
                mm2s_done <= 1'b0;
            end
        end
    end

    assign s_ready = (s2mm_st == RUN);
    assign wr_en   = s_valid && s_ready;
    assign wr_addr = wr_base + wr_cnt[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2mm_st   <= IDLE;
            s2mm_done <= 1'b0;
            wr_base   <= '0;
            wr_n      <= '0;
            wr_cnt    <= '0;
        end else if (s2mm_st == RUN) begin
            if (wr_en) begin
                wr_cnt <= wr_cnt + 32'd1;
                if (s_last || (wr_cnt == wr_n - 32'd1)) begin
                    s2mm_st   <= DONE;
                    s2mm_done <= 1'b1;
                end
            end
        end else if (go_s2mm) begin
            wr_base <= out_base;
            wr_n    <= go_beats;
            wr_cnt  <= '0;
            if (go_beats == 32'd0) begin
                s2mm_st   <= DONE;
                s2mm_done <= 1'b1;
            end else begin
                s2mm_st   <= RUN;
                s2mm_done <= 1'b0;
            end
        end
    end

`ifdef DMA_PATH_FIFO_EN
    logic [DATA_W:0] fifo_mem [0:3];
    logic [1:0]      fifo_wp, fifo_rp;
    logic [2:0]      fifo_cnt;
    logic            push, pop;

    assign m_ready          = (fifo_cnt != 3'd4);
    assign s_valid          = (fifo_cnt != 3'd0);
    assign {s_last, s_data} = fifo_mem[fifo_rp];
    assign push             = m_valid && m_ready;
    assign pop              = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wp] <= {m_last, m_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) fifo_wp <= fifo_wp + 2'd1;
            if (pop)  fifo_rp <= fifo_rp + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
`else
    assign s_valid = m_valid;
    assign s_data  = m_data;
    assign s_last  = m_last;
    assign m_ready = s_ready;
`endif
endmodule

// File: tb/tb_dma_path_top.sv
// Directed bench for dma_path_top: table of transfers checked against a shadow BRAM,
// plus hand-written sequences for ignored go pulses and reset mid-transfer.

module tb_dma_path_top;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rstn;
    logic              go_mm2s, go_s2mm;
    logic [31:0]       byte_len;
    logic [ADDR_W-1:0] in_base, out_base;
    logic              mm2s_done, s2mm_done;

    always #5 clk = ~clk;

    dma_path_top #(.ADDR_W(ADDR_W), .DATA_W(128)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .go_mm2s   (go_mm2s),
        .go_s2mm   (go_s2mm),
        .byte_len  (byte_len),
        .in_base   (in_base),
        .out_base  (out_base),
        .mm2s_done (mm2s_done),
        .s2mm_done (s2mm_done)
    );

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [31:0] len;
        bit          mm2s_first;
        int          beats;
    } vec_t;

    vec_t         vecs [8];
    logic [127:0] shadow [0:DEPTH-1];
    int           total = 0;
    int           bad   = 0;

    function automatic logic [127:0] word_of(input int i);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[16*j +: 16] = {8'(i), 8'(j)};
        return w;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input bit s2mm, input bit mm2s);
        @(negedge clk);
        go_s2mm = s2mm;
        go_mm2s = mm2s;
        @(negedge clk);
        go_s2mm = 1'b0;
        go_mm2s = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!(mm2s_done && s2mm_done) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic model(input logic [7:0] src, input logic [7:0] dst, input int beats);
        logic [127:0] snap [0:DEPTH-1];
        for (int a = 0; a < DEPTH; a++) snap[a] = shadow[a];
        for (int k = 0; k < beats; k++) shadow[8'(dst + 8'(k))] = snap[8'(src + 8'(k))];
    endtask

    task automatic check_mem(input string name);
        int errs  = 0;
        int first = -1;
        for (int a = 0; a < DEPTH; a++) begin
            if (dut.u_bram.mem[a] !== shadow[a]) begin
                errs++;
                if (first < 0) first = a;
            end
        end
        check($sformatf("%s mismatching_words(first_addr=%0d)", name, first), 128'(errs), 128'(0));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mm2s_done"}, 128'(mm2s_done), 128'(0));
        check({tag, "_s2mm_done"}, 128'(s2mm_done), 128'(0));
        check({tag, "_mm2s_idle"}, 128'(dut.mm2s_st), 128'(0));
        check({tag, "_s2mm_idle"}, 128'(dut.s2mm_st), 128'(0));
    endtask

    initial begin
        int           cyc;
        bit           early;
        logic [127:0] keep;

        vecs[0] = '{8'h00, 8'h80, 32'd256, 1'b0, 16};
        vecs[1] = '{8'h10, 8'h40, 32'd40,  1'b0, 3};
        vecs[2] = '{8'h20, 8'h60, 32'd0,   1'b0, 0};
        vecs[3] = '{8'hF8, 8'h90, 32'd256, 1'b0, 16};
        vecs[4] = '{8'h30, 8'hA0, 32'd17,  1'b0, 2};
        vecs[5] = '{8'h05, 8'hB0, 32'd16,  1'b0, 1};
        vecs[6] = '{8'h60, 8'hC0, 32'd256, 1'b1, 16};
        vecs[7] = '{8'h50, 8'hFE, 32'd64,  1'b0, 4};

        rstn     = 1'b0;
        go_mm2s  = 1'b0;
        go_s2mm  = 1'b0;
        byte_len = '0;
        in_base  = '0;
        out_base = '0;
        for (int a = 0; a < DEPTH; a++) begin
            dut.u_bram.mem[a] = word_of(a);
            shadow[a]         = word_of(a);
        end
        repeat (3) @(negedge clk);
        check_idle("reset");
        rstn = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            byte_len = vecs[r].len;
            in_base  = vecs[r].src;
            out_base = vecs[r].dst;
            keep     = shadow[8'(vecs[r].dst + 8'(vecs[r].beats))];
            if (vecs[r].mm2s_first) begin
                pulse(1'b0, 1'b1);
                early = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (mm2s_done) early = 1'b1;
                end
                check($sformatf("row%0d_mm2s_done_before_arm", r), 128'(early), 128'(0));
                pulse(1'b1, 1'b0);
            end else begin
                pulse(1'b1, 1'b0);
                if (vecs[r].beats > 0)
                    check($sformatf("row%0d_s2mm_done_cleared", r), 128'(s2mm_done), 128'(0));
                pulse(1'b0, 1'b1);
            end
            wait_done(cyc);
            if (vecs[r].beats == 0)
                check($sformatf("row%0d_zero_len_latency", r), 128'(cyc <= 1), 128'(1));
            check($sformatf("row%0d_mm2s_done", r), 128'(mm2s_done), 128'(1));
            check($sformatf("row%0d_s2mm_done", r), 128'(s2mm_done), 128'(1));
            model(vecs[r].src, vecs[r].dst, vecs[r].beats);
            check_mem($sformatf("row%0d_mem", r));
            if (vecs[r].beats > 0 && vecs[r].beats < 16)
                check($sformatf("row%0d_word_after_block", r),
                      dut.u_bram.mem[8'(vecs[r].dst + 8'(vecs[r].beats))], keep);
        end

        // Go pulses with new bases while both engines run must be ignored.
        byte_len = 32'd128;
        in_base  = 8'h70;
        out_base = 8'hD0;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        in_base  = 8'h00;
        out_base = 8'h00;
        pulse(1'b1, 1'b1);
        wait_done(cyc);
        check("rego_mm2s_done", 128'(mm2s_done), 128'(1));
        check("rego_s2mm_done", 128'(s2mm_done), 128'(1));
        model(8'h70, 8'hD0, 8);
        check_mem("rego_mem");

        // Reset in the middle of a 16-beat transfer, then a fresh go pair.
        byte_len = 32'd256;
        in_base  = 8'h08;
        out_base = 8'hE0;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_idle("midrst");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("postrst");
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_done(cyc);
        check("rerun_mm2s_done", 128'(mm2s_done), 128'(1));
        check("rerun_s2mm_done", 128'(s2mm_done), 128'(1));
        model(8'h08, 8'hE0, 16);
        check_mem("rerun_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
